// File: rtl/s_store_scheduler_pkg.sv
// Shared definitions for the S-type store scheduler: store width codes and the queue entry layout.
package s_store_scheduler_pkg;

   localparam int PKG_DATA_WIDTH  = 32;
   localparam int PKG_RF_WIDTH    = 5;
   localparam int PKG_FUNC3_WIDTH = 3;
   localparam int PKG_TAG_WIDTH   = 7;

   localparam logic [PKG_FUNC3_WIDTH-1:0] FUNC3_SB = 3'b000;
   localparam logic [PKG_FUNC3_WIDTH-1:0] FUNC3_SH = 3'b001;
   localparam logic [PKG_FUNC3_WIDTH-1:0] FUNC3_SW = 3'b010;

   // Entry field widths are fixed here; the top-level width parameters must match them.
   typedef struct packed {
      logic [PKG_RF_WIDTH-1:0]    rs1;
      logic [PKG_RF_WIDTH-1:0]    rs2;
      logic [PKG_FUNC3_WIDTH-1:0] func3;
      logic [PKG_DATA_WIDTH-1:0]  imm;
      logic [PKG_TAG_WIDTH-1:0]   tag;
   } store_entry_t;

   function automatic logic is_store_func3(input logic [PKG_FUNC3_WIDTH-1:0] f);
      return (f == FUNC3_SB) || (f == FUNC3_SH) || (f == FUNC3_SW);
   endfunction

endpackage

// File: rtl/s_store_scheduler_compact.sv
// Combinational lane compaction: legality, prefix-popcount write offsets, enqueue count and first illegal lane.
module s_store_compact
   import s_store_scheduler_pkg::*;
#(
   parameter int IPC         = 4,
   parameter int FUNC3_WIDTH = 3,
   parameter int CW          = $clog2(IPC + 1),
   parameter int IW          = (IPC > 1) ? $clog2(IPC) : 1
)(
   input  logic [IPC-1:0]             in_valid,
   input  logic [IPC*FUNC3_WIDTH-1:0] in_func3,
   output logic [IPC-1:0]             lane_legal,
   output logic [IPC*CW-1:0]          lane_offset,
   output logic [CW-1:0]              n_enq,
   output logic                       any_illegal,
   output logic [IW-1:0]              first_illegal
);

   always_comb begin
      lane_legal    = '0;
      lane_offset   = '0;
      n_enq         = '0;
      any_illegal   = 1'b0;
      first_illegal = '0;
      for (int i = 0; i < IPC; i++) begin
         lane_legal[i]            = in_valid[i] && is_store_func3(in_func3[i*FUNC3_WIDTH +: FUNC3_WIDTH]);
         lane_offset[i*CW +: CW]  = n_enq;
         if (lane_legal[i]) begin
            n_enq = n_enq + CW'(1);
         end
         // Only the lowest-index illegal lane is reported.
         if (in_valid[i] && !lane_legal[i] && !any_illegal) begin
            any_illegal   = 1'b1;
            first_illegal = IW'(i);
         end
      end
   end

endmodule

// File: rtl/s_store_scheduler.sv
// In-order store scheduler: compacts up to IPC decoded stores per cycle into a circular queue, issues one per cycle.
module s_store_scheduler
   import s_store_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH  = PKG_DATA_WIDTH,
   parameter int RF_WIDTH    = PKG_RF_WIDTH,
   parameter int FUNC3_WIDTH = PKG_FUNC3_WIDTH,
   parameter int IPC         = 4,
   parameter int TAG_WIDTH   = PKG_TAG_WIDTH,
   parameter int DEPTH       = 8
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [IPC-1:0]              in_valid,
   input  logic [IPC*RF_WIDTH-1:0]     in_rs1,
   input  logic [IPC*RF_WIDTH-1:0]     in_rs2,
   input  logic [IPC*FUNC3_WIDTH-1:0]  in_func3,
   input  logic [IPC*DATA_WIDTH-1:0]   in_imm,
   input  logic [IPC*TAG_WIDTH-1:0]    in_tag,
   output logic                        in_ready,
   output logic                        st_valid,
   input  logic                        st_ready,
   output logic [RF_WIDTH-1:0]         st_rs1,
   output logic [RF_WIDTH-1:0]         st_rs2,
   output logic [FUNC3_WIDTH-1:0]      st_func3,
   output logic [DATA_WIDTH-1:0]       st_imm,
   output logic [TAG_WIDTH-1:0]        st_tag,
   output logic                        err_valid,
   output logic [TAG_WIDTH-1:0]        err_tag,
   input  logic                        flush,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;
   localparam int CW   = $clog2(IPC + 1);
   localparam int IW   = (IPC > 1) ? $clog2(IPC) : 1;

   logic [IPC-1:0]    lane_legal;
   logic [IPC*CW-1:0] lane_offset;
   logic [CW-1:0]     n_enq;
   logic              any_illegal;
   logic [IW-1:0]     first_illegal;

   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [CNTW-1:0]      count_q, count_d;
   logic                 err_valid_q, err_valid_d;
   logic [TAG_WIDTH-1:0] err_tag_q, err_tag_d;
   logic                 enq_fire, deq_fire;

   store_entry_t queue_mem [DEPTH];
   store_entry_t head;

   s_store_compact #(
      .IPC         (IPC),
      .FUNC3_WIDTH (FUNC3_WIDTH),
      .CW          (CW),
      .IW          (IW)
   ) u_compact (
      .in_valid      (in_valid),
      .in_func3      (in_func3),
      .lane_legal    (lane_legal),
      .lane_offset   (lane_offset),
      .n_enq         (n_enq),
      .any_illegal   (any_illegal),
      .first_illegal (first_illegal)
   );

   // Credit check uses registered occupancy only, with no credit for a same-cycle dequeue.
   assign in_ready  = count_q <= CNTW'(DEPTH - IPC);
   assign st_valid  = count_q != '0;
   assign head      = queue_mem[rd_ptr_q];
   assign st_rs1    = head.rs1;
   assign st_rs2    = head.rs2;
   assign st_func3  = head.func3;
   assign st_imm    = head.imm;
   assign st_tag    = head.tag;
   assign err_valid = err_valid_q;
   assign err_tag   = err_tag_q;
   assign count     = count_q;

   assign enq_fire = in_ready && !flush;
   assign deq_fire = st_valid && st_ready && !flush;

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      err_valid_d = 1'b0;
      err_tag_d   = err_tag_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq_fire) begin
            wr_ptr_d = wr_ptr_q + PW'(n_enq);
         end
         if (deq_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d     = count_q + (enq_fire ? CNTW'(n_enq) : '0) - CNTW'(deq_fire);
         err_valid_d = enq_fire && any_illegal;
         if (err_valid_d) begin
            err_tag_d = in_tag[int'(first_illegal)*TAG_WIDTH +: TAG_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         err_valid_q <= 1'b0;
         err_tag_q   <= '0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         err_valid_q <= err_valid_d;
         err_tag_q   <= err_tag_d;
      end
   end

   // Payload storage is not reset; occupancy alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (enq_fire && !rst) begin
         for (int i = 0; i < IPC; i++) begin
            if (lane_legal[i]) begin
               queue_mem[wr_ptr_q + PW'(lane_offset[i*CW +: CW])] <= '{
                  rs1:   in_rs1[i*RF_WIDTH +: RF_WIDTH],
                  rs2:   in_rs2[i*RF_WIDTH +: RF_WIDTH],
                  func3: in_func3[i*FUNC3_WIDTH +: FUNC3_WIDTH],
                  imm:   in_imm[i*DATA_WIDTH +: DATA_WIDTH],
                  tag:   in_tag[i*TAG_WIDTH +: TAG_WIDTH]
               };
            end
         end
      end
   end

endmodule

// File: tb/tb_s_store_scheduler.sv
// Self-checking bench for s_store_scheduler: queue-based reference model plus directed scenarios and random traffic.
module tb_s_store_scheduler;

   localparam int IPC   = 4;
   localparam int DEPTH = 8;

   typedef struct {
      int rs1;
      int rs2;
      int func3;
      longint imm;
      int tag;
   } model_entry_t;

   logic          clk;
   logic          rst;
   logic [3:0]    in_valid;
   logic [19:0]   in_rs1;
   logic [19:0]   in_rs2;
   logic [11:0]   in_func3;
   logic [127:0]  in_imm;
   logic [27:0]   in_tag;
   logic          in_ready;
   logic          st_valid;
   logic          st_ready;
   logic [4:0]    st_rs1;
   logic [4:0]    st_rs2;
   logic [2:0]    st_func3;
   logic [31:0]   st_imm;
   logic [6:0]    st_tag;
   logic          err_valid;
   logic [6:0]    err_tag;
   logic          flush;
   logic [3:0]    count;

   int checks = 0;
   int fails  = 0;
   bit check_en = 0;

   model_entry_t model_q[$];
   bit           exp_err_valid = 0;
   int           exp_err_tag = 0;

   s_store_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_func3  (in_func3),
      .in_imm    (in_imm),
      .in_tag    (in_tag),
      .in_ready  (in_ready),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_rs1    (st_rs1),
      .st_rs2    (st_rs2),
      .st_func3  (st_func3),
      .st_imm    (st_imm),
      .st_tag    (st_tag),
      .err_valid (err_valid),
      .err_tag   (err_tag),
      .flush     (flush),
      .count     (count)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Reference model: an in-order queue updated from the rules, sampled on the same edge as the DUT.
   always @(posedge clk) begin
      if (rst) begin
         model_q.delete();
         exp_err_valid = 0;
         exp_err_tag   = 0;
      end else if (flush) begin
         model_q.delete();
         exp_err_valid = 0;
      end else begin
         bit ready_now;
         bit seen_bad;
         ready_now = (DEPTH - model_q.size()) >= IPC;
         if (model_q.size() != 0 && st_ready) begin
            void'(model_q.pop_front());
         end
         exp_err_valid = 0;
         seen_bad = 0;
         if (ready_now) begin
            for (int i = 0; i < IPC; i++) begin
               if (in_valid[i]) begin
                  int f;
                  f = int'(in_func3[i*3 +: 3]);
                  if (f <= 2) begin
                     model_entry_t e;
                     e.rs1   = int'(in_rs1[i*5 +: 5]);
                     e.rs2   = int'(in_rs2[i*5 +: 5]);
                     e.func3 = f;
                     e.imm   = longint'(in_imm[i*32 +: 32]);
                     e.tag   = int'(in_tag[i*7 +: 7]);
                     model_q.push_back(e);
                  end else if (!seen_bad) begin
                     seen_bad      = 1;
                     exp_err_valid = 1;
                     exp_err_tag   = int'(in_tag[i*7 +: 7]);
                  end
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("in_ready", longint'(in_ready), longint'((DEPTH - model_q.size()) >= IPC));
         checkOutput("st_valid", longint'(st_valid), longint'(model_q.size() != 0));
         checkOutput("count", longint'(count), longint'(model_q.size()));
         checkOutput("err_valid", longint'(err_valid), longint'(exp_err_valid));
         if (exp_err_valid) checkOutput("err_tag", longint'(err_tag), longint'(exp_err_tag));
         if (model_q.size() != 0) begin
            checkOutput("st_tag", longint'(st_tag), longint'(model_q[0].tag));
            checkOutput("st_rs1", longint'(st_rs1), longint'(model_q[0].rs1));
            checkOutput("st_rs2", longint'(st_rs2), longint'(model_q[0].rs2));
            checkOutput("st_func3", longint'(st_func3), longint'(model_q[0].func3));
            checkOutput("st_imm", longint'(st_imm), model_q[0].imm);
         end
      end
   end

   function automatic logic [27:0] tags4(input int t0, input int t1, input int t2, input int t3);
      return {7'(t3), 7'(t2), 7'(t1), 7'(t0)};
   endfunction

   function automatic logic [11:0] f3x4(input int f0, input int f1, input int f2, input int f3);
      return {3'(f3), 3'(f2), 3'(f1), 3'(f0)};
   endfunction

   // Drive one cycle of inputs just after a rising edge, then step to just after the next one.
   task automatic applyStimulus(input logic [3:0] v, input logic [11:0] f3, input logic [27:0] tags,
                                input logic rdy, input logic fl, input logic rs);
      in_valid = v;
      in_func3 = f3;
      in_tag   = tags;
      st_ready = rdy;
      flush    = fl;
      rst      = rs;
      for (int i = 0; i < IPC; i++) begin
         in_rs1[i*5 +: 5]   = 5'($urandom);
         in_rs2[i*5 +: 5]   = 5'($urandom);
         in_imm[i*32 +: 32] = $urandom;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rdy);
      applyStimulus(4'b0000, 12'h0, 28'h0, rdy, 1'b0, 1'b0);
   endtask

   initial begin
      logic [11:0] sw4;
      sw4 = f3x4(2, 2, 2, 2);
      in_valid = '0; in_rs1 = '0; in_rs2 = '0; in_func3 = '0; in_imm = '0; in_tag = '0;
      st_ready = 0; flush = 0; rst = 1;
      @(posedge clk); #1;
      applyStimulus(4'b0000, 12'h0, 28'h0, 1'b0, 1'b0, 1'b1);
      check_en = 1;
      checkOutput("reset count", longint'(count), 0);
      checkOutput("reset in_ready", longint'(in_ready), 1);
      checkOutput("reset st_valid", longint'(st_valid), 0);
      checkOutput("reset err_tag", longint'(err_tag), 0);

      // Four stores in one cycle issue 1..4 back to back.
      applyStimulus(4'b1111, sw4, tags4(1, 2, 3, 4), 1'b1, 1'b0, 1'b0);
      checkOutput("burst count peak", longint'(count), 4);
      checkOutput("burst first tag", longint'(st_tag), 1);
      for (int k = 2; k <= 4; k++) begin
         idle(1'b1);
         checkOutput("burst next tag", longint'(st_tag), longint'(k));
      end
      idle(1'b1);
      checkOutput("burst drained", longint'(st_valid), 0);

      // Sparse lanes compact with no gap.
      applyStimulus(4'b1010, sw4, tags4(0, 5, 0, 7), 1'b0, 1'b0, 1'b0);
      checkOutput("sparse count", longint'(count), 2);
      checkOutput("sparse head", longint'(st_tag), 5);
      idle(1'b1);
      checkOutput("sparse second", longint'(st_tag), 7);
      idle(1'b1);

      // Illegal func3 on lanes 1 and 3: report tag 9, enqueue 8 and 10.
      applyStimulus(4'b1111, f3x4(2, 3, 0, 7), tags4(8, 9, 10, 11), 1'b0, 1'b0, 1'b0);
      checkOutput("illegal err_valid", longint'(err_valid), 1);
      checkOutput("illegal err_tag", longint'(err_tag), 9);
      checkOutput("illegal count", longint'(count), 2);
      checkOutput("illegal head", longint'(st_tag), 8);
      idle(1'b1);
      checkOutput("illegal pulse ends", longint'(err_valid), 0);
      checkOutput("illegal second", longint'(st_tag), 10);
      idle(1'b1);

      // Fill to full, then drain under continued pressure and wrap pointers.
      applyStimulus(4'b1111, sw4, tags4(20, 21, 22, 23), 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b1111, sw4, tags4(24, 25, 26, 27), 1'b0, 1'b0, 1'b0);
      checkOutput("full count", longint'(count), 8);
      checkOutput("full in_ready", longint'(in_ready), 0);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(4'b1111, sw4, tags4(28, 29, 30, 31), 1'b1, 1'b0, 1'b0);
         checkOutput("drain in_ready", longint'(in_ready), longint'(k == 4));
         checkOutput("drain head", longint'(st_tag), longint'(20 + k));
      end
      applyStimulus(4'b1111, sw4, tags4(28, 29, 30, 31), 1'b1, 1'b0, 1'b0);
      checkOutput("refill count", longint'(count), 7);
      for (int k = 0; k < 3; k++) idle(1'b1);
      checkOutput("wrap head", longint'(st_tag), 28);
      for (int k = 0; k < 4; k++) idle(1'b1);
      checkOutput("wrap drained", longint'(count), 0);

      // Flush with count=6 beats a same-cycle enqueue, dequeue and error.
      applyStimulus(4'b1111, sw4, tags4(40, 41, 42, 43), 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0011, sw4, tags4(44, 45, 0, 0), 1'b0, 1'b0, 1'b0);
      checkOutput("preflush count", longint'(count), 6);
      applyStimulus(4'b1111, f3x4(2, 5, 2, 2), tags4(50, 51, 52, 53), 1'b1, 1'b1, 1'b0);
      checkOutput("flush count", longint'(count), 0);
      checkOutput("flush st_valid", longint'(st_valid), 0);
      checkOutput("flush err_valid", longint'(err_valid), 0);

      // Reset mid-stream with count=5 and a held error tag.
      applyStimulus(4'b1111, sw4, tags4(60, 61, 62, 63), 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0011, f3x4(2, 4, 0, 0), tags4(64, 99, 0, 0), 1'b0, 1'b0, 1'b0);
      checkOutput("prereset count", longint'(count), 5);
      checkOutput("prereset err_tag", longint'(err_tag), 99);
      applyStimulus(4'b1111, sw4, tags4(70, 71, 72, 73), 1'b1, 1'b0, 1'b1);
      checkOutput("midreset count", longint'(count), 0);
      checkOutput("midreset st_valid", longint'(st_valid), 0);
      checkOutput("midreset err_valid", longint'(err_valid), 0);
      checkOutput("midreset err_tag", longint'(err_tag), 0);
      checkOutput("midreset in_ready", longint'(in_ready), 1);

      // Random traffic checked by the model each cycle.
      for (int n = 0; n < 3000; n++) begin
         logic [11:0] f3;
         logic [27:0] tg;
         for (int i = 0; i < IPC; i++) begin
            f3[i*3 +: 3] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            tg[i*7 +: 7] = 7'($urandom);
         end
         applyStimulus(4'($urandom), f3, tg, 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 199) == 0));
      end
      idle(1'b1);
      check_en = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/s_store_scheduler.md
# s_store_scheduler

In-order store scheduler between the IPC-wide S-type decode lanes and the single data-memory store port. Each cycle it accepts up to IPC decoded stores (rs1, rs2, func3, sign-extended imm, tag), compacts them in lane order into a circular queue, and issues them one per cycle to the store port over a valid/ready handshake. It also rejects stores with illegal func3, reports them, and supports a pipeline flush.

## Interface
Parameters:
- DATA_WIDTH, 32, immediate width
- RF_WIDTH, 5, register index width
- FUNC3_WIDTH, 3, func3 width
- IPC, 4, decode lanes per cycle
- TAG_WIDTH, 7, instruction tag width
- DEPTH, 8, queue entries; power of two, DEPTH >= IPC

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  IPC  per-lane S-type valid; lane 0 oldest
- in_rs1  in  IPC*RF_WIDTH  lane i at [i*RF_WIDTH +: RF_WIDTH]
- in_rs2  in  IPC*RF_WIDTH  packed the same way
- in_func3  in  IPC*FUNC3_WIDTH  packed the same way
- in_imm  in  IPC*DATA_WIDTH  sign-extended S immediate, packed the same way
- in_tag  in  IPC*TAG_WIDTH  packed the same way
- in_ready  out  1  whole lane group accepted this cycle
- st_valid  out  1  head entry valid
- st_ready  in  1  store port consumes head
- st_rs1, st_rs2  out  RF_WIDTH  head operands
- st_func3  out  FUNC3_WIDTH  head width code
- st_imm  out  DATA_WIDTH  head immediate
- st_tag  out  TAG_WIDTH  head tag
- err_valid  out  1  one-cycle pulse: illegal store rejected
- err_tag  out  TAG_WIDTH  tag of the rejected store
- flush  in  1  discard all queued and incoming stores
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Legal func3 values: 000 (SB), 001 (SH), 010 (SW). A lane is legal when in_valid[i] is high and func3 is legal.
- in_ready = (DEPTH - count) >= IPC; it depends only on registered count, never on in_valid or st_ready.
- Enqueue fires when in_ready is high and flush is low. Legal lanes are written to wr_ptr, wr_ptr+1, … in ascending lane order with no gaps. n_enq = popcount(legal lanes).
- Illegal valid lanes are not enqueued. On the next cycle err_valid=1 and err_tag = tag of the lowest-index illegal lane; other illegal lanes in the same cycle are dropped silently. This happens only when enqueue fires.
- Dequeue fires when st_valid and st_ready are both high. st_* outputs are driven directly from the entry at rd_ptr. st_valid = (count != 0).
- Next count = count + n_enq - deq. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Flush takes priority over everything. Next cycle: count=0, rd_ptr=wr_ptr=0, err_valid=0. The same-cycle enqueue and dequeue are both suppressed, including the st handshake, so the store port must ignore that cycle.
- Reset forces count=0, pointers=0, st_valid=0, err_valid=0, err_tag=0, in_ready=1. Queue payload is not reset, and st_* data is don't-care while st_valid=0.
- Reset asserted mid-operation discards all entries exactly like flush.

## Timing
- Enqueue-to-issue latency is 1 cycle. A store accepted in cycle N can appear at st_* in cycle N+1, at the earliest.
- Steady state is one store issued per cycle while st_ready is held high.
- A simultaneous enqueue and dequeue in one cycle is legal. in_ready gives no credit for the same-cycle dequeue.
- Full boundary: with count > DEPTH-IPC, in_ready=0 even if fewer than IPC lanes are valid.
- Empty boundary: with count=0, st_valid=0 and no dequeue occurs regardless of st_ready.
- err_valid is registered, asserted 1 cycle after the offending accept.

## Structure
- Shared package holds the store func3 constants (SB/SH/SW) and the queue entry typedef {rs1, rs2, func3, imm, tag}.
- One sub-module: s_store_compact. It is combinational and computes per-lane legal, per-lane write offset (prefix popcount), n_enq, and the first illegal lane index. The top level holds the queue array, pointers, count and err registers.

## Test plan
- Reset, then IPC stores in one cycle (tags 1-4, func3 010) with st_ready=1 -> st_tag issues 1,2,3,4 on consecutive cycles starting the next cycle, and count peaks at 4.
- Lanes valid 1010 with tags 5,7 -> queue holds 5 then 7 with no gap, and count=2.
- Lane 1 func3=011 (tag 9), lane 3 func3=111 (tag 11), others legal -> err_valid pulse with err_tag=9, and only lanes 0 and 2 are enqueued.
- st_ready=0 with 4 stores/cycle -> after 2 cycles count=8 and in_ready=0. Then st_ready=1 -> in_ready returns only when count<=4, and the pointers wrap correctly.
- count=6 with flush=1, in_valid=1111 and st_ready=1 all in the same cycle -> next cycle count=0, st_valid=0, no err_valid.
- rst asserted mid-stream with count=5 -> next cycle all outputs are at their reset values and in_ready=1.
